// File: rtl/idft_bin_real_mdl_if.sv
// Handshake bundle for the single-bin inverse DFT model.
// Coefficient offer on one side, real sample stream on the other.
interface idft_bin_real_mdl_if;
    logic coef_valid;
    logic coef_ready;
    real  X_re;
    real  X_im;
    logic sample_valid;
    logic sample_ready;
    real  x;
    logic sample_last;
    logic block_done;

    // Producer of coefficients / consumer of samples (e.g. a bench).
    modport master (
        output coef_valid,
        output X_re,
        output X_im,
        output sample_ready,
        input  coef_ready,
        input  sample_valid,
        input  x,
        input  sample_last,
        input  block_done
    );

    // The tone generator itself.
    modport slave (
        input  coef_valid,
        input  X_re,
        input  X_im,
        input  sample_ready,
        output coef_ready,
        output sample_valid,
        output x,
        output sample_last,
        output block_done
    );
endinterface

// File: rtl/idft_bin_real_mdl.sv
// Behavioural inverse single-bin DFT: one complex bin in, N real samples out.
// Samples come from a rotating phasor (c, s) advanced once per transfer.
module idft_bin_real_mdl #(
    parameter int N = 1024,
    parameter int K = 7
) (
    input  logic                clk,
    input  logic                rst,
    idft_bin_real_mdl_if.slave  bus
);

    if (N < 2) begin : g_bad_n
        $fatal(1, "idft_bin_real_mdl: N must be >= 2");
    end

    if (K < 0 || K >= N) begin : g_bad_k
        $fatal(1, "idft_bin_real_mdl: K must satisfy 0 <= K < N");
    end

    localparam int NW = (N > 2) ? $clog2(N) : 1;

    localparam logic [NW-1:0] N_LAST = NW'(N - 1);

    localparam real PI = 3.14159265358979323846;

    localparam real DTHETA = 2.0 * PI * real'(K) / real'(N);

    // DC and Nyquist bins carry no mirrored half, so they get half the gain.
    localparam bit  SELF_CONJ = (K == 0) || ((N % 2 == 0) && (K == N / 2));
    localparam real GAIN = SELF_CONJ ? (1.0 / real'(N)) : (2.0 / real'(N));

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t        state_q;
    real           a_q;
    real           b_q;
    real           c_q;
    real           s_q;
    logic [NW-1:0] n_q;
    real           x_q;
    logic          valid_q;
    logic          ready_q;
    logic          last_q;
    logic          done_q;

    real cs_w;
    real ss_w;
    real c_d;
    real s_d;
    real x_d;

    // Per-step rotation is fixed by the bin; evaluated once.
    assign cs_w = $cos(DTHETA);
    assign ss_w = $sin(DTHETA);

    // Next phasor position and the sample it produces.
    always_comb begin
        c_d = c_q * cs_w - s_q * ss_w;
        s_d = s_q * cs_w + c_q * ss_w;
        x_d = GAIN * (a_q * c_d - b_q * s_d);
    end

    // Control FSM with registered handshake outputs and phasor state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= 0.0;
            b_q     <= 0.0;
            c_q     <= 1.0;
            s_q     <= 0.0;
            n_q     <= '0;
            x_q     <= 0.0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.coef_valid) begin
                        a_q     <= bus.X_re;
                        b_q     <= bus.X_im;
                        c_q     <= 1.0;
                        s_q     <= 0.0;
                        n_q     <= '0;
                        // Phase zero: cos=1, sin=0.
                        x_q     <= GAIN * bus.X_re;
                        last_q  <= 1'b0;
                        valid_q <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.sample_ready) begin
                        if (n_q == N_LAST) begin
                            valid_q <= 1'b0;
                            ready_q <= 1'b1;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            c_q    <= c_d;
                            s_q    <= s_d;
                            x_q    <= x_d;
                            n_q    <= n_q + NW'(1);
                            last_q <= (n_q == N_LAST - NW'(1));
                        end
                    end
                end
            endcase
        end
    end

    assign bus.coef_ready   = ready_q;
    assign bus.sample_valid = valid_q;
    assign bus.x            = x_q;
    assign bus.sample_last  = last_q;
    assign bus.block_done   = done_q;

endmodule

// File: tb/tb_idft_bin_real_mdl.sv
// Randomised bench for idft_bin_real_mdl against a direct-trig tone model.
// Two instances: K=7 (main) and K=0 (DC gain / held coef_valid).
module tb_idft_bin_real_mdl;

    localparam int  NS = 1024;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst = 1'b1;

    idft_bin_real_mdl_if ia ();
    idft_bin_real_mdl_if ib ();

    idft_bin_real_mdl #(.N(NS), .K(7)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    idft_bin_real_mdl #(.N(NS), .K(0)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    always #5 clk = ~clk;

    int  vectors = 0;
    int  miscompares = 0;
    real got_a [NS];
    real blk1  [NS];
    real src   [NS];

    task automatic check(input string tag, input real got,
                         input real exp, input real tol);
        real d;
        vectors++;
        d = (got > exp) ? (got - exp) : (exp - got);
        if (!(d <= tol)) begin
            miscompares++;
            $display("FAIL %s: got %0.15g expected %0.15g", tag, got, exp);
        end
    endtask

    // Ideal tone straight from the definition, phase reduced mod N.
    function automatic real ideal(input real a, input real b,
                                  input int k, input int n);
        real g;
        real th;
        g  = (k == 0 || k == NS / 2) ? 1.0 / NS : 2.0 / NS;
        th = 2.0 * PI * real'((k * n) % NS) / real'(NS);
        return g * (a * $cos(th) - b * $sin(th));
    endfunction

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // One block on the K=7 instance; stop_at>=0 returns mid-block.
    task automatic run_a(input real a, input real b,
                         input int pct, input int stop_at);
        int  n = 0;
        int  cyc = 0;
        bit  rdy;
        bit  stalled = 1'b0;
        real px = 0.0;
        real tol;
        tol = 1e-9 * ((rabs(a) > rabs(b)) ? rabs(a) : rabs(b))
              * (2.0 / NS) + 1e-12;
        @(negedge clk);
        check("idle_coef_ready", real'(ia.coef_ready), 1.0, 0.0);
        ia.coef_valid = 1'b1;
        ia.X_re = a;
        ia.X_im = b;
        @(negedge clk);
        ia.coef_valid = 1'b0;
        ia.X_re = -3.0e5;
        ia.X_im = 7.0e5;
        check("run_coef_ready", real'(ia.coef_ready), 0.0, 0.0);
        while (n < NS && cyc < 8 * NS) begin
            if (stop_at >= 0 && n == stop_at) return;
            check("valid", real'(ia.sample_valid), 1.0, 0.0);
            check("x", ia.x, ideal(a, b, 7, n), tol);
            check("last", real'(ia.sample_last),
                  (n == NS - 1) ? 1.0 : 0.0, 0.0);
            if (stalled) check("hold", ia.x, px, 0.0);
            got_a[n] = ia.x;
            px = ia.x;
            rdy = (pct >= 100) || ($urandom_range(0, 99) < pct);
            ia.sample_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) n++;
            stalled = !rdy;
        end
        ia.sample_ready = 1'b0;
        check("transfers", real'(n), real'(NS), 0.0);
        check("block_done", real'(ia.block_done), 1.0, 0.0);
        check("valid_off", real'(ia.sample_valid), 0.0, 0.0);
        check("coef_ready_back", real'(ia.coef_ready), 1.0, 0.0);
        @(negedge clk);
        check("done_pulse", real'(ia.block_done), 0.0, 0.0);
    endtask

    // DC bin with coef_valid held through the whole block.
    task automatic run_b();
        int n = 0;
        int cyc = 0;
        @(negedge clk);
        ib.coef_valid = 1'b1;
        ib.X_re = 1024.0;
        ib.X_im = 0.0;
        ib.sample_ready = 1'b1;
        @(negedge clk);
        while (ib.sample_valid && cyc < NS + 16) begin
            check("k0_x", ib.x, 1.0, 1e-12);
            check("k0_coef_ready", real'(ib.coef_ready), 0.0, 0.0);
            check("k0_last", real'(ib.sample_last),
                  (n == NS - 1) ? 1.0 : 0.0, 0.0);
            @(negedge clk);
            n++;
            cyc++;
        end
        check("k0_transfers", real'(n), real'(NS), 0.0);
        check("k0_done", real'(ib.block_done), 1.0, 0.0);
        check("k0_coef_ready_back", real'(ib.coef_ready), 1.0, 0.0);
        @(negedge clk);
        ib.coef_valid = 1'b0;
        check("k0_reaccept", real'(ib.sample_valid), 1.0, 0.0);
        check("k0_done_pulse", real'(ib.block_done), 0.0, 0.0);
        cyc = 0;
        while (ib.sample_valid && cyc < NS + 16) begin
            @(negedge clk);
            cyc++;
        end
        check("k0_drain", real'(cyc), real'(NS), 0.0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        real a;
        real b;
        real amp;
        real phi;
        real xr;
        real xi;
        real th;
        real tol;

        ia.coef_valid = 1'b0;
        ia.X_re = 0.0;
        ia.X_im = 0.0;
        ia.sample_ready = 1'b0;
        ib.coef_valid = 1'b0;
        ib.X_re = 0.0;
        ib.X_im = 0.0;
        ib.sample_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_coef_ready", real'(ia.coef_ready), 1.0, 0.0);
        check("rst_valid", real'(ia.sample_valid), 0.0, 0.0);
        check("rst_x", ia.x, 0.0, 0.0);
        check("rst_last", real'(ia.sample_last), 0.0, 0.0);
        check("rst_done", real'(ia.block_done), 0.0, 0.0);
        rst = 1'b0;
        ia.sample_ready = 1'b1;
        @(negedge clk);
        check("idle_ignores_ready", real'(ia.sample_valid), 0.0, 0.0);
        ia.sample_ready = 1'b0;

        // Cosine tone, no backpressure.
        run_a(512.0, 0.0, 100, -1);
        check("t1_x0", got_a[0], 1.0, 0.0);
        for (int i = 0; i < NS; i++) blk1[i] = got_a[i];

        // Negative imaginary part gives a sine tone.
        run_a(0.0, -512.0, 100, -1);
        check("t2_x0", got_a[0], 0.0, 0.0);
        check("t2_x256", got_a[256], -1.0, 1e-9);

        // Same tone under random stalls must be bit-identical.
        run_a(512.0, 0.0, 50, -1);
        for (int i = 0; i < NS; i++) check("t3_same", got_a[i], blk1[i], 0.0);

        // DC bin.
        run_b();

        // Reset in the middle of a block.
        run_a(512.0, 0.0, 100, 300);
        #2 rst = 1'b1;
        #1;
        check("t5_valid_drop", real'(ia.sample_valid), 0.0, 0.0);
        check("t5_x_zero", ia.x, 0.0, 0.0);
        check("t5_last_zero", real'(ia.sample_last), 0.0, 0.0);
        ia.sample_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_coef_ready", real'(ia.coef_ready), 1.0, 0.0);
        run_a(512.0, 0.0, 100, -1);
        check("t5_x0", got_a[0], 1.0, 0.0);

        // Random coefficients with random backpressure.
        for (int r = 0; r < 2; r++) begin
            a = real'($urandom_range(0, 4000)) / 4.0 - 500.0;
            b = real'($urandom_range(0, 4000)) / 4.0 - 500.0;
            run_a(a, b, int'($urandom_range(30, 90)), -1);
        end

        // Round trip through a forward single-bin DFT.
        amp = real'($urandom_range(1, 2000)) / 8.0;
        phi = 2.0 * PI * real'($urandom_range(0, 999)) / 1000.0;
        xr = 0.0;
        xi = 0.0;
        for (int n = 0; n < NS; n++) begin
            th = 2.0 * PI * real'((7 * n) % NS) / real'(NS);
            src[n] = amp * $cos(th + phi);
            xr = xr + src[n] * $cos(th);
            xi = xi - src[n] * $sin(th);
        end
        run_a(xr, xi, 70, -1);
        tol = 1e-9 * ((amp > 1.0) ? amp : 1.0);
        for (int n = 0; n < NS; n++) check("t6_roundtrip", got_a[n], src[n], tol);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
